quad_encoder_emulator: RTL and testbench

- Generates two-channel quadrature signals (enc_a, enc_b) that emulate a rotary encoder. Output goes to the quadrature decoder input or to external hardware.
- Takes commands as direction + step count + step period over a valid/ready handshake. Emits exactly that many Gray-code edges at a fixed rate.
- Keeps a signed-wrap position count matching what a correct decoder must read.
- Used for closed-loop motor-control bring-up without a physical encoder, and as a self-test stimulus source.

---
 rtl/quad_pkg.sv | 18 +
 rtl/quad_phase_step.sv | 25 ++
 rtl/quad_encoder_emulator.sv | 160 ++++++++++++++++
 tb/tb_quad_encoder_emulator.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared quadrature definitions: Gray phase codes, direction encoding and the
// emulator FSM states. The decoder imports the same package so both agree on direction.
package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/quad_phase_step.sv
// Next Gray phase {a,b} for one quadrature edge in the given direction.
// Forward walks 00->01->11->10->00; reverse walks the same ring backwards.
module quad_phase_step
  import quad_pkg::*;
(
  input  logic [1:0] phase_i,
  input  logic       dir_i,
  output logic [1:0] phase_o
);

  logic fwd;

  assign fwd = (dir_i == DIR_FWD);

  always_comb begin
    phase_o = PH_00;
    case (phase_i)
      PH_00: phase_o = fwd ? PH_01 : PH_10;
      PH_01: phase_o = fwd ? PH_11 : PH_00;
      PH_11: phase_o = fwd ? PH_10 : PH_01;
      PH_10: phase_o = fwd ? PH_00 : PH_11;
    endcase
  end

endmodule

// File: rtl/quad_encoder_emulator.sv
// Rotary-encoder emulator: emits cmd_steps Gray edges every cmd_period clocks and
// tracks the wrapped position. Define QENC_INDEX_EN to add the CPR index output enc_z.
//
// Command handshake: a command transfers on a rising clk_50M edge where
// cmd_valid and cmd_ready are both 1; cmd_valid may be held across cycles and
// the command fields must stay stable while it is high and unaccepted.
module quad_encoder_emulator
  import quad_pkg::*;
#(
  parameter int CNT_W = 20,
  parameter int DIV_W = 16
`ifdef QENC_INDEX_EN
  ,
  parameter int CPR   = 1024
`endif
) (
  input  logic             clk_50M,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic             enc_a,
  output logic             enc_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] position,
`ifdef QENC_INDEX_EN
  output logic             enc_z,
`endif
  output logic             fsm_state_o
);

  state_t           state_q;
  logic [1:0]       phase_q;
  logic [1:0]       phase_d;
  logic             dir_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] position_q;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] div_q;
  logic             busy_q;
  logic             done_q;
  logic             ready_q;

  logic [DIV_W-1:0] period_eff;
  logic             edge_now;

  // A zero period would stall the divider forever, so it runs as one clock.
  assign period_eff = (cmd_period == '0) ? DIV_W'(1) : cmd_period;
  assign edge_now   = (state_q == RUN) && !abort && (div_q == DIV_W'(1));

  quad_phase_step u_phase_step (
    .phase_i (phase_q),
    .dir_i   (dir_q),
    .phase_o (phase_d)
  );

  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      state_q    <= IDLE;
      phase_q    <= PH_00;
      dir_q      <= DIR_FWD;
      rem_q      <= '0;
      position_q <= '0;
      period_q   <= '0;
      div_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && ready_q) begin
            if (cmd_steps == '0) begin
              done_q <= 1'b1;
            end else begin
              dir_q    <= cmd_dir;
              rem_q    <= cmd_steps;
              period_q <= period_eff;
              div_q    <= period_eff;
              busy_q   <= 1'b1;
              ready_q  <= 1'b0;
              state_q  <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            // Abort beats a coinciding edge; phase and position hold.
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else if (edge_now) begin
            phase_q    <= phase_d;
            position_q <= (dir_q == DIR_REV) ? position_q - 1'b1 : position_q + 1'b1;
            rem_q      <= rem_q - 1'b1;
            div_q      <= period_q;
            if (rem_q == CNT_W'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            div_q <= div_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign enc_a       = phase_q[1];
  assign enc_b       = phase_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign cmd_ready   = ready_q;
  assign position    = position_q;
  assign fsm_state_o = state_q;

`ifdef QENC_INDEX_EN
  localparam int IDX_W = (CPR > 1) ? $clog2(CPR) : 1;

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [1:0]       phase_nx;
  logic             enc_z_q;

  always_comb begin
    idx_d    = idx_q;
    phase_nx = phase_q;
    if (edge_now) begin
      phase_nx = phase_d;
      if (dir_q == DIR_REV) begin
        idx_d = (idx_q == '0) ? IDX_W'(CPR - 1) : idx_q - 1'b1;
      end else begin
        idx_d = (idx_q == IDX_W'(CPR - 1)) ? '0 : idx_q + 1'b1;
      end
    end
  end

  // enc_z is registered from the values the phase and index take this edge.
  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      idx_q   <= '0;
      enc_z_q <= 1'b1;
    end else begin
      idx_q   <= idx_d;
      enc_z_q <= (idx_d == '0) && (phase_nx == PH_00);
    end
  end

  assign enc_z = enc_z_q;
`endif

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Randomized and directed bench for quad_encoder_emulator, checked every cycle
// against a timeline model (edge k of a command lands at acceptance + k*period).
module tb_quad_encoder_emulator;

  localparam int CNT_W = 20;
  localparam int DIV_W = 16;
`ifdef QENC_INDEX_EN
  localparam int CPR = 4;
`endif

  logic             clk_50M    = 1'b0;
  logic             reset      = 1'b0;
  logic             cmd_valid  = 1'b0;
  logic             cmd_dir    = 1'b0;
  logic [CNT_W-1:0] cmd_steps  = '0;
  logic [DIV_W-1:0] cmd_period = '0;
  logic             abort      = 1'b0;
  logic             cmd_ready;
  logic             enc_a;
  logic             enc_b;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] position;
  logic             fsm_state;
`ifdef QENC_INDEX_EN
  logic             enc_z;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  // ---------------- clock ----------------
  always #10 clk_50M = ~clk_50M;

  quad_encoder_emulator #(
    .CNT_W (CNT_W),
    .DIV_W (DIV_W)
`ifdef QENC_INDEX_EN
    ,
    .CPR   (CPR)
`endif
  ) dut (
    .clk_50M     (clk_50M),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_dir     (cmd_dir),
    .cmd_steps   (cmd_steps),
    .cmd_period  (cmd_period),
    .abort       (abort),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .busy        (busy),
    .done        (done),
    .position    (position),
`ifdef QENC_INDEX_EN
    .enc_z       (enc_z),
`endif
    .fsm_state_o (fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase is a pure function of net position: the Gray ring indexed by position mod 4.
  logic [1:0]       gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int               cyc = 0;
  bit               started = 0;
  bit               m_rst = 1;
  bit               m_run = 0, m_busy = 0, m_done = 0, m_ready = 1, m_acc = 0, m_dir = 0;
  int               m_t = 0, m_per = 1, m_n = 0;
  logic [CNT_W-1:0] m_pos = '0;
  int               last_done_cyc = -1, last_acc_cyc = -1;

  always @(posedge clk_50M) begin
    cyc++;
    started = 1;
    m_done  = 0;
    m_acc   = 0;
    m_rst   = !reset;
    if (!reset) begin
      m_run = 0; m_busy = 0; m_ready = 1; m_pos = '0;
    end else if (m_run) begin
      if (abort) begin
        m_run = 0; m_busy = 0; m_ready = 1;
      end else if ((cyc - m_t) % m_per == 0) begin
        m_pos = m_dir ? m_pos + 20'd1 : m_pos - 20'd1;
        if ((cyc - m_t) / m_per == m_n) begin
          m_run = 0; m_busy = 0; m_ready = 1; m_done = 1;
          last_done_cyc = cyc;
        end
      end
    end else if (cmd_valid) begin
      m_acc = 1;
      last_acc_cyc = cyc;
      if (cmd_steps == '0) begin
        m_done = 1;
        last_done_cyc = cyc;
      end else begin
        m_run = 1; m_busy = 1; m_ready = 0;
        m_t   = cyc;
        m_per = (cmd_period == '0) ? 1 : int'(cmd_period);
        m_n   = int'(cmd_steps);
        m_dir = cmd_dir;
      end
    end
  end

  // ---------------- per-cycle scoreboard ----------------
  logic [1:0] prev_ab = 2'b00;

  always @(negedge clk_50M) begin
    if (started) begin
      check("phase", {30'd0, enc_a, enc_b}, {30'd0, gray[m_pos[1:0]]});
      check("position", {12'd0, position}, {12'd0, m_pos});
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_ready});
      check("state", {31'd0, fsm_state}, {31'd0, m_run});
`ifdef QENC_INDEX_EN
      check("enc_z", {31'd0, enc_z},
            {31'd0, ((m_pos % CPR) == 0) && (m_pos[1:0] == 2'b00)});
`endif
      if (!m_rst && ({enc_a, enc_b} != prev_ab))
        check("one_toggle", $countones({enc_a, enc_b} ^ prev_ab), 1);
      prev_ab = {enc_a, enc_b};
      if (done) n_done++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  // Offers a command and returns on the negedge after it is taken; cmd_valid stays high.
  task automatic send(input bit dir, input int steps, input int per);
    int budget = 2000;
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_steps  = CNT_W'(steps);
    cmd_period = DIV_W'(per);
    do begin
      @(posedge clk_50M);
      #1;
      budget--;
    end while (!m_acc && budget > 0);
    if (!m_acc) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk_50M);
  endtask

  task automatic wait_idle();
    int b = 0;
    while (busy && b < 5000) begin
      @(negedge clk_50M);
      b++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick(3);
    reset = 1'b1;
    tick(2);
    check("rst_position", {12'd0, position}, 32'd0);
    check("rst_phase", {30'd0, enc_a, enc_b}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Forward: 8 edges at 3-cycle spacing, one done pulse.
    n_done = 0;
    send(1'b1, 8, 3);
    cmd_valid = 1'b0;
    wait_idle();
    tick(2);
    check("fwd_position", {12'd0, position}, 32'd8);
    check("fwd_done_cnt", n_done, 1);

    // Reverse from reset wraps below zero.
    do_reset();
    send(1'b0, 2, 1);
    cmd_valid = 1'b0;
    wait_idle();
    tick(1);
    check("rev_position", {12'd0, position}, 32'h000FFFFE);
    check("rev_phase", {30'd0, enc_a, enc_b}, 32'd3);

    // Abort after four edges: no done, nothing more for 50 cycles.
    do_reset();
    n_done = 0;
    send(1'b1, 100, 5);
    cmd_valid = 1'b0;
    tick(20);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    tick(50);
    check("abort_position", {12'd0, position}, 32'd4);
    check("abort_done_cnt", n_done, 0);

    // Abort landing on a scheduled edge suppresses that edge.
    send(1'b1, 10, 5);
    cmd_valid = 1'b0;
    tick(4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(3);
    check("abort_coinc_position", {12'd0, position}, 32'd4);

    // Zero steps: done only; zero period: one edge per clock.
    n_done = 0;
    send(1'b1, 0, 3);
    cmd_valid = 1'b0;
    tick(2);
    check("zero_steps_done_cnt", n_done, 1);
    check("zero_steps_position", {12'd0, position}, 32'd4);
    send(1'b0, 3, 0);
    cmd_valid = 1'b0;
    wait_idle();
    tick(1);
    check("zero_period_position", {12'd0, position}, 32'd1);

    // Back-to-back with reversal, cmd_valid held throughout.
    do_reset();
    send(1'b1, 5, 2);
    send(1'b0, 5, 2);
    cmd_valid = 1'b0;
    check("b2b_gap", last_acc_cyc - last_done_cyc, 1);
    wait_idle();
    tick(1);
    check("b2b_position", {12'd0, position}, 32'd0);
    check("b2b_phase", {30'd0, enc_a, enc_b}, 32'd0);

    // Random commands with occasional aborts and resets.
    for (int i = 0; i < 30; i++) begin
      send(1'($urandom_range(0, 1)), $urandom_range(0, 12), $urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) cmd_valid = 1'b0;
      case ($urandom_range(0, 5))
        0: begin
          cmd_valid = 1'b0;
          tick($urandom_range(0, 10));
          abort = 1'b1;
          tick(1);
          abort = 1'b0;
        end
        1: begin
          cmd_valid = 1'b0;
          tick($urandom_range(0, 6));
          do_reset();
        end
        default: ;
      endcase
      cmd_valid = 1'b0;
      wait_idle();
      tick($urandom_range(0, 3));
    end

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
